// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame assembler.
//   frm_state_t       : frame FSM states.
//   SYNC_BYTE_DEFAULT : default frame start marker.
//   TIMEOUT_DEFAULT   : default inter-byte gap limit in clk cycles
//                       (3 byte-times at 19200 baud with a 50 MHz clock).
//   frm_csum()        : frame checksum over the two command bytes.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        CSUM = 2'd3
    } frm_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam int         TIMEOUT_DEFAULT   = 78120;

    function automatic logic [7:0] frm_csum(input logic [7:0] hi, input logic [7:0] lo);
        return hi ^ lo;
    endfunction

endpackage

// File: rtl/uart_gap_tmr.sv
// Inter-byte gap timer for the frame assembler.
//   clk, rst : clock, synchronous active-high reset.
//   run      : frame in progress; the counter is held at 0 while low.
//   kick     : byte accepted this cycle; clears the counter.
//   expired  : single-cycle flag, counter at TIMEOUT-1 with no kick.
module uart_gap_tmr
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // A byte in the same cycle beats the timeout.
        expired = run && !kick && (cnt_q == LAST);
        cnt_d   = cnt_q + CW'(1);
        // Clearing on expiry keeps the counter from wrapping while the
        // FSM is returning to IDLE.
        if (!run || kick || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_rcv.sv
// Command-frame assembler downstream of the UART receiver.
// Frame: SYNC_BYTE, cmd high, cmd low, checksum (high ^ low).
//   clk, rst    : clock, synchronous active-high reset.
//   rx_rdy      : receiver holds a byte in rx_data.
//   rx_data     : received byte.
//   clr_rx_rdy  : consume strobe back to the receiver (combinational).
//   cmd         : last valid command {high, low}.
//   cmd_rdy     : sticky new-command flag, cleared by clr_cmd_rdy.
//   clr_cmd_rdy : consumer acknowledge.
//   frm_err     : one-cycle pulse per dropped frame.
//   err_cnt     : saturating dropped-frame count.
module uart_frame_rcv
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frm_err,
    output logic [7:0]  err_cnt
);

    frm_state_t  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        expired;
    logic        drop;

    // Every offered byte is taken immediately, even in reset, so the
    // receiver never presents the same byte twice.
    assign clr_rx_rdy = rx_rdy;

    uart_gap_tmr #(.TIMEOUT(TIMEOUT)) u_gap_tmr (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q != IDLE),
        .kick    (rx_rdy),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        drop      = 1'b0;

        // Acknowledge first so a same-cycle valid frame re-sets the flag.
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        if (rx_rdy) begin
            unique case (state_q)
                IDLE: if (rx_data == SYNC_BYTE) state_d = HIGH;
                HIGH: begin
                    hi_d    = rx_data;
                    state_d = LOW;
                end
                LOW: begin
                    lo_d    = rx_data;
                    state_d = CSUM;
                end
                CSUM: begin
                    state_d = IDLE;
                    if (rx_data == frm_csum(hi_q, lo_q)) begin
                        cmd_d     = {hi_q, lo_q};
                        cmd_rdy_d = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (expired) begin
            state_d = IDLE;
            drop    = 1'b1;
        end

        frm_err_d = drop;
        err_cnt_d = err_cnt_q;
        if (drop && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            frm_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            frm_err_q <= frm_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = frm_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_rcv.sv
module tb_uart_frame_rcv;

    localparam int TIMEOUT = 78120;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frm_err;
    logic [7:0]  err_cnt;

    uart_frame_rcv dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frm_err     (frm_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] cmd;
    } evt_t;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_clr = 0;
    int   exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / scoreboard pop ----------------
    logic        cmd_rdy_prev = 1'b0;
    logic [15:0] cmd_prev = '0;
    logic        frm_err_prev = 1'b0;

    task automatic pop_evt(input bit is_err, input logic [15:0] c);
        evt_t e;
        if (exp_q.size() == 0) begin
            chk(is_err ? "unexpected_err" : "unexpected_cmd", 32'(c), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind", 32'(is_err), 32'(e.is_err));
            if (!is_err && !e.is_err) chk("evt_cmd", 32'(c), 32'(e.cmd));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frm_err) begin
                chk("frm_err_width", 32'(frm_err_prev), 32'd0);
                pop_evt(1'b1, 16'h0);
            end
            if (cmd_rdy && (!cmd_rdy_prev || cmd != cmd_prev)) begin
                pop_evt(1'b0, cmd);
            end
        end
        cmd_rdy_prev <= cmd_rdy;
        cmd_prev     <= cmd;
        frm_err_prev <= frm_err;
    end

    always @(posedge clk) begin
        if (clr_rx_rdy) n_clr++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_rdy = 1'b0;
        end
    endtask

    task automatic push_ok(input logic [15:0] c);
        evt_t e;
        e.is_err = 1'b0;
        e.cmd    = c;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        evt_t e;
        e.is_err = 1'b1;
        e.cmd    = '0;
        exp_q.push_back(e);
        if (exp_err < 255) exp_err++;
    endtask

    task automatic ack();
        @(negedge clk);
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("ack_cmd_rdy", 32'(cmd_rdy), 32'd0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst         = 1'b1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd",     32'(cmd),     32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("rst_frm_err", 32'(frm_err), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        rx_rdy = 1'b1;
        #1;
        chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h1);
        @(negedge clk);
        rx_rdy = 1'b0;
        rst    = 1'b0;
        idle(2);

        // bad checksum from reset: cmd stays 0000
        send(8'hAA); send(8'h12); send(8'h34); send(8'h27);
        push_err();
        idle(1);
        chk("bad_frm_err", 32'(frm_err), 32'h1);
        chk("bad_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("bad_cmd",     32'(cmd),     32'h0);
        chk("bad_cmd_rdy", 32'(cmd_rdy), 32'h0);
        idle(1);
        chk("bad_frm_err_off", 32'(frm_err), 32'h0);

        // back-to-back valid frame
        c0 = n_clr;
        send(8'hAA); send(8'h12); send(8'h34); send(8'h26);
        push_ok(16'h1234);
        idle(1);
        chk("b2b_cmd",     32'(cmd),         32'h1234);
        chk("b2b_cmd_rdy", 32'(cmd_rdy),     32'h1);
        chk("b2b_clr_cnt", 32'(n_clr - c0),  32'd4);
        chk("b2b_err_cnt", 32'(err_cnt),     32'(exp_err));
        ack();

        // junk before sync dropped silently
        send(8'h55); send(8'h00);
        send(8'hAA); send(8'h12); send(8'h34); send(8'h26);
        push_ok(16'h1234);
        idle(1);
        chk("junk_cmd",     32'(cmd),     32'h1234);
        chk("junk_cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("junk_err_cnt", 32'(err_cnt), 32'(exp_err));
        ack();

        // gap timeout: fires exactly TIMEOUT cycles after last byte
        send(8'hAA); send(8'h12);
        push_err();
        idle(1);
        idle(TIMEOUT - 1);
        chk("tmo_early", 32'(frm_err), 32'h0);
        idle(1);
        chk("tmo_frm_err", 32'(frm_err), 32'h1);
        chk("tmo_err_cnt", 32'(err_cnt), 32'(exp_err));
        send(8'h34); send(8'h26);
        idle(2);
        chk("tmo_stray_cmd_rdy", 32'(cmd_rdy), 32'h0);
        send(8'hAA); send(8'hAB); send(8'hCD); send(8'h66);
        push_ok(16'hABCD);
        idle(1);
        chk("tmo_next_cmd", 32'(cmd), 32'hABCD);

        // ack on the same edge as a valid frame: set wins
        send(8'hAA); send(8'h12); send(8'h34);
        send(8'h26);
        clr_cmd_rdy = 1'b1;
        push_ok(16'h1234);
        idle(1);
        clr_cmd_rdy = 1'b0;
        chk("setwins_cmd_rdy", 32'(cmd_rdy), 32'h1);
        // overwrite while pending
        send(8'hAA); send(8'h5A); send(8'h5A); send(8'h00);
        push_ok(16'h5A5A);
        idle(1);
        chk("ovr_cmd",     32'(cmd),     32'h5A5A);
        chk("ovr_cmd_rdy", 32'(cmd_rdy), 32'h1);

        // saturation
        for (int i = 0; i < 260; i++) begin
            send(8'hAA); send(8'h01); send(8'h02); send(8'hFF);
            push_err();
        end
        idle(2);
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_cmd",     32'(cmd),     32'h5A5A);

        // reset mid-frame
        send(8'hAA); send(8'h12);
        @(negedge clk);
        rst     = 1'b1;
        rx_data = 8'h34;
        #1;
        chk("midrst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h1);
        @(negedge clk);
        rst    = 1'b0;
        rx_rdy = 1'b0;
        exp_err = 0;
        chk("midrst_cmd",     32'(cmd),     32'h0);
        chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("midrst_frm_err", 32'(frm_err), 32'h0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'h0);
        idle(2);
        chk("midrst_frm_err2", 32'(frm_err), 32'h0);
        send(8'hAA); send(8'h01); send(8'h02); send(8'h03);
        push_ok(16'h0102);
        idle(1);
        chk("post_rst_cmd",     32'(cmd),     32'h0102);
        chk("post_rst_cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'h0);
        idle(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
